// File: rtl/robo_pkg.sv
// Shared definitions for the robot navigation actuator: motor drive codes,
// actuator state encoding and the action kinds used by the optional odometry.
package robo_pkg;

    localparam logic [1:0] MOTOR_PARADO = 2'b00;
    localparam logic [1:0] MOTOR_FRENTE = 2'b01;
    localparam logic [1:0] MOTOR_RE     = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AVANCA = 3'd1,
        GIRA   = 3'd2,
        CURVA  = 3'd3,
        REMOVE = 3'd4,
        PAUSA  = 3'd5
    } estado_atuador_t;

    // Kind of the action currently (or most recently) executed.
    typedef enum logic [1:0] {
        ACAO_PASSO   = 2'd0,
        ACAO_GIRO    = 2'd1,
        ACAO_REMOCAO = 2'd2
    } acao_t;

    // Largest of the four timing parameters; sizes the shared down-counter.
    function automatic int max_ciclos(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/atuador_motores_contador_tempo.sv
// Loadable down-counter shared by every timed state of the actuator.
// A load wins over the decrement; the count saturates at zero.
module contador_tempo #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load has priority, otherwise decrement while enabled and non-zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/atuador_motores.sv
// Motor/arm actuator: turns the level commands avancar, girar and remover
// into timed drive sequences followed by a dead time and a one-cycle done.
// Optional odometry counters are built when ATUADOR_ODOMETRIA_EN is defined.
module atuador_motores
    import robo_pkg::*;
#(
    parameter int STEP_CYCLES = 8,
    parameter int TURN_CYCLES = 6,
    parameter int ARM_CYCLES  = 10,
    parameter int DEAD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        avancar,
    input  logic        girar,
    input  logic        remover,
    output logic [1:0]  motor_esq,
    output logic [1:0]  motor_dir,
    output logic        braco,
    output logic        busy,
    output logic        done
`ifdef ATUADOR_ODOMETRIA_EN
    ,
    output logic [15:0] passos,
    output logic [15:0] giros,
    output logic [7:0]  remocoes
`endif
);

    localparam int MAX_CICLOS = max_ciclos(STEP_CYCLES, TURN_CYCLES, ARM_CYCLES, DEAD_CYCLES);
    localparam int CW         = $clog2(MAX_CICLOS) + 1;

    localparam logic [CW-1:0] CARGA_PASSO   = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CARGA_GIRO    = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] CARGA_REMOCAO = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] CARGA_PAUSA   = CW'(DEAD_CYCLES - 1);

    estado_atuador_t estado_q, estado_d;
    acao_t           acao_q, acao_d;
    logic [1:0]      motor_esq_q, motor_esq_d;
    logic [1:0]      motor_dir_q, motor_dir_d;
    logic            braco_q, braco_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            cont_load;
    logic [CW-1:0]   cont_valor;
    logic            cont_enable;
    logic [CW-1:0]   cont_count;
    logic            cont_zero;

    contador_tempo #(
        .W (CW)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .load       (cont_load),
        .load_value (cont_valor),
        .enable     (cont_enable),
        .count      (cont_count),
        .zero       (cont_zero)
    );

    // The counter only runs while an action or the dead time is in progress.
    assign cont_enable = (estado_q != IDLE);

    // Next state, counter load and the registered outputs of the next state.
    always_comb begin
        estado_d   = estado_q;
        acao_d     = acao_q;
        cont_load  = 1'b0;
        cont_valor = '0;

        case (estado_q)
            IDLE: begin
                if (remover) begin
                    estado_d   = REMOVE;
                    acao_d     = ACAO_REMOCAO;
                    cont_load  = 1'b1;
                    cont_valor = CARGA_REMOCAO;
                end else if (avancar && girar) begin
                    estado_d   = CURVA;
                    acao_d     = ACAO_GIRO;
                    cont_load  = 1'b1;
                    cont_valor = CARGA_GIRO;
                end else if (girar) begin
                    estado_d   = GIRA;
                    acao_d     = ACAO_GIRO;
                    cont_load  = 1'b1;
                    cont_valor = CARGA_GIRO;
                end else if (avancar) begin
                    estado_d   = AVANCA;
                    acao_d     = ACAO_PASSO;
                    cont_load  = 1'b1;
                    cont_valor = CARGA_PASSO;
                end
            end
            AVANCA, GIRA, CURVA, REMOVE: begin
                if (cont_zero) begin
                    estado_d   = PAUSA;
                    cont_load  = 1'b1;
                    cont_valor = CARGA_PAUSA;
                end
            end
            PAUSA: begin
                if (cont_zero) begin
                    estado_d = IDLE;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear with the state.
        motor_esq_d = MOTOR_PARADO;
        motor_dir_d = MOTOR_PARADO;
        braco_d     = 1'b0;
        busy_d      = (estado_d != IDLE);
        done_d      = (estado_q == PAUSA) && cont_zero;

        case (estado_d)
            AVANCA: begin
                motor_esq_d = MOTOR_FRENTE;
                motor_dir_d = MOTOR_FRENTE;
            end
            GIRA: begin
                motor_esq_d = MOTOR_FRENTE;
                motor_dir_d = MOTOR_RE;
            end
            CURVA: begin
                motor_esq_d = MOTOR_FRENTE;
                motor_dir_d = MOTOR_PARADO;
            end
            REMOVE: begin
                braco_d = 1'b1;
            end
            default: begin
                motor_esq_d = MOTOR_PARADO;
                motor_dir_d = MOTOR_PARADO;
            end
        endcase
    end

    // State and registered outputs; reset aborts any action without a done.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= IDLE;
            acao_q      <= ACAO_PASSO;
            motor_esq_q <= MOTOR_PARADO;
            motor_dir_q <= MOTOR_PARADO;
            braco_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            acao_q      <= acao_d;
            motor_esq_q <= motor_esq_d;
            motor_dir_q <= motor_dir_d;
            braco_q     <= braco_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign motor_esq = motor_esq_q;
    assign motor_dir = motor_dir_q;
    assign braco     = braco_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef ATUADOR_ODOMETRIA_EN
    logic [15:0] passos_q, passos_d;
    logic [15:0] giros_q, giros_d;
    logic [7:0]  remocoes_q, remocoes_d;

    // Count each completed action by kind; the update lands with the done pulse.
    always_comb begin
        passos_d   = passos_q;
        giros_d    = giros_q;
        remocoes_d = remocoes_q;
        if (done_d) begin
            case (acao_q)
                ACAO_PASSO:   passos_d   = passos_q + 16'd1;
                ACAO_GIRO:    giros_d    = giros_q + 16'd1;
                ACAO_REMOCAO: remocoes_d = remocoes_q + 8'd1;
                default:      passos_d   = passos_q;
            endcase
        end
    end

    // Odometry registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            passos_q   <= '0;
            giros_q    <= '0;
            remocoes_q <= '0;
        end else begin
            passos_q   <= passos_d;
            giros_q    <= giros_d;
            remocoes_q <= remocoes_d;
        end
    end

    assign passos   = passos_q;
    assign giros    = giros_q;
    assign remocoes = remocoes_q;
`endif

endmodule
